// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// mips_ctrl_pkg : shared states, opcodes and control encodings for the
//                 8-bit MIPS multicycle controller. Honours MIPS_CTRL_ADDI_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Ungated control word; the top applies memReady/zero/reset qualification.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic [3:0] ir_sel;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_fetch;
    logic       pc_write_cond;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    ok = (op == OP_LB) || (op == OP_SB) || (op == OP_RTYPE) ||
         (op == OP_BEQ) || (op == OP_J);
`ifdef MIPS_CTRL_ADDI_EN
    ok = ok || (op == OP_ADDI);
`endif
    return ok;
  endfunction

  function automatic logic [3:0] fetch_byte_sel(input state_t s);
    logic [3:0] sel;
    case (s)
      S_FETCH1: sel = 4'b0001;
      S_FETCH2: sel = 4'b0010;
      S_FETCH3: sel = 4'b0100;
      S_FETCH4: sel = 4'b1000;
      default:  sel = 4'b0000;
    endcase
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_ctrl_outdec.sv
// ============================================================================
// mips_ctrl_outdec : pure state-to-control-word decode (MIPS_CTRL_ADDI_EN
//                    adds the ADDI execute/writeback words).
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_IDLE;
    case (state_i)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        ctrl_o.mem_read       = 1'b1;
        ctrl_o.i_or_d         = 1'b0;
        ctrl_o.alu_src_a      = 1'b0;
        ctrl_o.alu_src_b      = SRCB_ONE;
        ctrl_o.alu_op         = ALUOP_ADD;
        ctrl_o.pc_source      = PCSRC_ALU;
        ctrl_o.ir_sel         = fetch_byte_sel(state_i);
        ctrl_o.pc_write_fetch = 1'b1;
      end
      S_DECODE: begin
        // Branch target is computed speculatively while the opcode decodes.
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_BRIMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_LBRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_LBWR: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_dst    = 1'b0;
      end
      S_SBWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REGB;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPEWR: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.mem_to_reg = 1'b0;
      end
      S_BEQEX: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REGB;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.pc_write_cond = 1'b1;
      end
      S_JEX: begin
        ctrl_o.pc_source = PCSRC_JUMP;
        ctrl_o.pc_write  = 1'b1;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_ADDIWR: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.mem_to_reg = 1'b0;
      end
`endif
      default: ctrl_o = CTRL_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
// mips_multicycle_ctrl : multicycle sequencer for the 8-bit MIPS datapath.
//                        Optional ADDI support via MIPS_CTRL_ADDI_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       memReady,
  output logic       memRead,
  output logic       memWrite,
  output logic       iOrD,
  output logic [3:0] irWrite,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       pcEn,
  output logic       illegalOp
);

  state_t state_q;
  state_t state_d;
  ctrl_t  w_ctrl;

  mips_ctrl_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (w_ctrl)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH1;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH1: if (memReady) state_d = S_FETCH2;
      S_FETCH2: if (memReady) state_d = S_FETCH3;
      S_FETCH3: if (memReady) state_d = S_FETCH4;
      S_FETCH4: if (memReady) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default:      state_d = S_FETCH1;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_SB)      state_d = S_SBWR;
        else if (op == OP_LB) state_d = S_LBRD;
        else                  state_d = S_FETCH1;
      end
      S_LBRD:    if (memReady) state_d = S_LBWR;
      S_SBWR:    if (memReady) state_d = S_FETCH1;
      S_RTYPEEX: state_d = S_RTYPEWR;
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDIEX:  state_d = S_ADDIWR;
`endif
      default:   state_d = S_FETCH1;
    endcase
  end

  // Reset forces every output low in the same cycle so no write leaks past it.
  always_comb begin
    memRead   = 1'b0;
    memWrite  = 1'b0;
    iOrD      = 1'b0;
    irWrite   = 4'b0000;
    regWrite  = 1'b0;
    regDst    = 1'b0;
    memToReg  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    pcSource  = 2'b00;
    pcEn      = 1'b0;
    illegalOp = 1'b0;
    if (!reset) begin
      memRead   = w_ctrl.mem_read;
      memWrite  = w_ctrl.mem_write;
      iOrD      = w_ctrl.i_or_d;
      irWrite   = w_ctrl.ir_sel & {4{memReady}};
      regWrite  = w_ctrl.reg_write;
      regDst    = w_ctrl.reg_dst;
      memToReg  = w_ctrl.mem_to_reg;
      aluSrcA   = w_ctrl.alu_src_a;
      aluSrcB   = w_ctrl.alu_src_b;
      aluOp     = w_ctrl.alu_op;
      pcSource  = w_ctrl.pc_source;
      pcEn      = (w_ctrl.pc_write_fetch & memReady) | w_ctrl.pc_write |
                  (w_ctrl.pc_write_cond & zero);
      illegalOp = (state_q == S_DECODE) && !op_supported(op);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// ============================================================================
// tb_mips_multicycle_ctrl : instruction-level model of the multicycle control
//                           sequence compared against the DUT every cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic       iOrD;
    logic [3:0] irWrite;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       pcEn;
    logic       illegalOp;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'b0;
  logic       zero = 1'b0;
  logic       memReady = 1'b0;
  logic       memRead, memWrite, iOrD, regWrite, regDst, memToReg, aluSrcA;
  logic       pcEn, illegalOp;
  logic [3:0] irWrite;
  logic [1:0] aluSrcB, aluOp, pcSource;

  mips_multicycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .zero      (zero),
    .memReady  (memReady),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .iOrD      (iOrD),
    .irWrite   (irWrite),
    .regWrite  (regWrite),
    .regDst    (regDst),
    .memToReg  (memToReg),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .aluOp     (aluOp),
    .pcSource  (pcSource),
    .pcEn      (pcEn),
    .illegalOp (illegalOp)
  );

  always #5 clk = ~clk;

  obs_t act;
  assign act = {memRead, memWrite, iOrD, irWrite, regWrite, regDst, memToReg,
                aluSrcA, aluSrcB, aluOp, pcSource, pcEn, illegalOp};

  int    checks = 0;
  int    errors = 0;
  obs_t  exp_cur = '0;
  logic  exp_valid = 1'b0;
  string step_name = "none";
  int    instr_cycles = 0;
  int    n_pcen = 0, n_regw = 0, n_ill = 0, n_memw = 0;

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, a, e);
    end
  endtask

  // Single compare process: every cycle with a valid expectation.
  always @(negedge clk) begin
    if (exp_valid) begin
      check(step_name, 32'(act), 32'(exp_cur));
      if (pcEn)      n_pcen++;
      if (regWrite)  n_regw++;
      if (illegalOp) n_ill++;
      if (memWrite)  n_memw++;
    end
  end

  // ---- model: what each step of an instruction must present ----
  function automatic obs_t e_fetch(input int n, input logic rdy);
    obs_t o = '0;
    o.memRead = 1'b1;
    o.aluSrcB = 2'b01;
    if (rdy) begin
      o.irWrite = 4'(1 << n);
      o.pcEn    = 1'b1;
    end
    return o;
  endfunction

  function automatic obs_t e_decode(input logic ill);
    obs_t o = '0;
    o.aluSrcB   = 2'b11;
    o.illegalOp = ill;
    return o;
  endfunction

  function automatic obs_t e_alu(input logic [1:0] srcb, input logic [1:0] aop);
    obs_t o = '0;
    o.aluSrcA = 1'b1;
    o.aluSrcB = srcb;
    o.aluOp   = aop;
    return o;
  endfunction

  function automatic obs_t e_mem(input logic wr);
    obs_t o = '0;
    o.memRead  = !wr;
    o.memWrite = wr;
    o.iOrD     = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_wb(input logic dst, input logic m2r);
    obs_t o = '0;
    o.regWrite = 1'b1;
    o.regDst   = dst;
    o.memToReg = m2r;
    return o;
  endfunction

  function automatic obs_t e_beq(input logic z);
    obs_t o = e_alu(2'b00, 2'b01);
    o.pcSource = 2'b01;
    o.pcEn     = z;
    return o;
  endfunction

  function automatic obs_t e_jmp();
    obs_t o = '0;
    o.pcSource = 2'b10;
    o.pcEn     = 1'b1;
    return o;
  endfunction

  function automatic logic addi_on();
`ifdef MIPS_CTRL_ADDI_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic cyc(input string nm, input obs_t e, input logic rdy);
    memReady  = rdy;
    exp_cur   = e;
    step_name = nm;
    exp_valid = 1'b1;
    instr_cycles++;
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction; abort_mem asserts reset after the memory-stage stalls.
  task automatic run_instr(input logic [5:0] opc, input logic z, input int fstall,
                           input int mstall, input logic idle_rdy, input logic abort_mem);
    logic legal;
    op = opc;
    zero = z;
    instr_cycles = 0;
    n_pcen = 0; n_regw = 0; n_ill = 0; n_memw = 0;
    for (int n = 0; n < 4; n++) begin
      for (int s = 0; s < fstall; s++) cyc("fetch_stall", e_fetch(n, 1'b0), 1'b0);
      cyc("fetch", e_fetch(n, 1'b1), 1'b1);
    end
    legal = (opc == 6'b100000) || (opc == 6'b101000) || (opc == 6'b000000) ||
            (opc == 6'b000100) || (opc == 6'b000010) ||
            ((opc == 6'b001000) && addi_on());
    cyc("decode", e_decode(!legal), idle_rdy);
    if (legal) begin
      case (opc)
        6'b100000, 6'b101000: begin
          cyc("memadr", e_alu(2'b10, 2'b00), idle_rdy);
          for (int s = 0; s < mstall; s++) cyc("mem_stall", e_mem(opc[3]), 1'b0);
          if (abort_mem) begin
            reset = 1'b1;
            cyc("reset_in_mem", '0, 1'b0);
            reset = 1'b0;
          end else begin
            cyc("mem", e_mem(opc[3]), 1'b1);
            if (!opc[3]) cyc("lbwr", e_wb(1'b0, 1'b1), idle_rdy);
          end
        end
        6'b000000: begin
          cyc("rtypeex", e_alu(2'b00, 2'b10), idle_rdy);
          cyc("rtypewr", e_wb(1'b1, 1'b0), idle_rdy);
        end
        6'b000100: cyc("beqex", e_beq(z), idle_rdy);
        6'b000010: cyc("jex", e_jmp(), idle_rdy);
        default: begin
          cyc("addiex", e_alu(2'b10, 2'b00), idle_rdy);
          cyc("addiwr", e_wb(1'b0, 1'b0), idle_rdy);
        end
      endcase
    end
  endtask

  initial begin
    // Reset held with busy inputs: all outputs must stay low.
    reset = 1'b1;
    op = 6'b111111;
    zero = 1'b1;
    for (int i = 0; i < 3; i++) cyc("in_reset", '0, 1'b1);
    reset = 1'b0;

    run_instr(6'b000000, 1'b0, 0, 0, 1'b1, 1'b0);
    check("rtype_cycles", instr_cycles, 7);
    check("rtype_pcen", n_pcen, 4);
    check("rtype_regw", n_regw, 1);

    run_instr(6'b100000, 1'b0, 0, 2, 1'b1, 1'b0);
    check("lb_stall_cycles", instr_cycles, 10);
    check("lb_regw", n_regw, 1);

    run_instr(6'b000100, 1'b1, 0, 0, 1'b0, 1'b0);
    check("beq_taken_cycles", instr_cycles, 6);
    check("beq_taken_pcen", n_pcen, 5);

    run_instr(6'b000100, 1'b0, 0, 0, 1'b1, 1'b0);
    check("beq_not_taken_cycles", instr_cycles, 6);
    check("beq_not_taken_pcen", n_pcen, 4);

    run_instr(6'b000010, 1'b0, 0, 0, 1'b0, 1'b0);
    check("j_cycles", instr_cycles, 6);
    check("j_pcen", n_pcen, 5);

    run_instr(6'b101000, 1'b1, 1, 1, 1'b1, 1'b0);
    check("sb_stall_cycles", instr_cycles, 12);
    check("sb_memw", n_memw, 2);

    run_instr(6'b111111, 1'b0, 0, 0, 1'b1, 1'b0);
    check("illegal_cycles", instr_cycles, 5);
    check("illegal_pulse", n_ill, 1);
    check("illegal_regw", n_regw, 0);
    check("illegal_memw", n_memw, 0);

    run_instr(6'b001000, 1'b0, 0, 0, 1'b1, 1'b0);
`ifdef MIPS_CTRL_ADDI_EN
    check("addi_cycles", instr_cycles, 7);
    check("addi_regw", n_regw, 1);
    check("addi_ill", n_ill, 0);
`else
    check("addi_cycles", instr_cycles, 5);
    check("addi_regw", n_regw, 0);
    check("addi_ill", n_ill, 1);
`endif

    // SB abandoned by reset while memory is stalled.
    run_instr(6'b101000, 1'b0, 0, 1, 1'b1, 1'b1);
    check("sb_abort_memw", n_memw, 1);

    run_instr(6'b000000, 1'b1, 1, 0, 1'b0, 1'b0);
    check("rtype_after_reset_cycles", instr_cycles, 11);
    check("rtype_after_reset_pcen", n_pcen, 4);

    run_instr(6'b100000, 1'b1, 2, 0, 1'b0, 1'b0);
    check("lb_fstall_cycles", instr_cycles, 16);
    check("lb_fstall_pcen", n_pcen, 4);

    exp_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
